// File: rtl/mult_acc_engine.sv
// Sequenced ROM-operand multiplier that stores or accumulates products into an
// internal result RAM, with a start/busy/done handshake and a combinational read port.
module mult_acc_engine #(
  parameter int DW     = 4,
  parameter int ROM_AW = 3,
  parameter int RAM_AW = 3,
  parameter int ACC_W  = 2 * DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROM_AW-1:0] addr1,
  input  logic [ROM_AW-1:0] addr2,
  input  logic [RAM_AW-1:0] dst,
  input  logic              mode,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DW-1:0]     rom_data,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic [ACC_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int DEPTH = 2 ** RAM_AW;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    MULT,
    WRITE,
    DONE
  } state_t;

  state_t              state;
  logic [ROM_AW-1:0]   addr2_q;
  logic [RAM_AW-1:0]   dst_q;
  logic                mode_q;
  logic [DW-1:0]       a_reg;
  logic [DW-1:0]       b_reg;
  logic [ACC_W-1:0]    p_reg;
  logic [ACC_W-1:0]    ram [DEPTH];

  logic [2*DW-1:0]     product;
  logic [ACC_W:0]      acc_sum;

  // The extra MSB of acc_sum is the carry out that raises the sticky overflow flag.
  assign product = a_reg * b_reg;
  assign acc_sum = {1'b0, ram[dst_q]} + {1'b0, p_reg};
  assign rd_data = ram[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr2_q  <= '0;
      dst_q    <= '0;
      mode_q   <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Operand A's address goes straight to the ROM so it is presented during FETCH_A.
            rom_addr <= addr1;
            addr2_q  <= addr2;
            dst_q    <= dst;
            mode_q   <= mode;
            busy     <= 1'b1;
            state    <= FETCH_A;
          end
        end
        FETCH_A: begin
          a_reg    <= rom_data;
          rom_addr <= addr2_q;
          state    <= FETCH_B;
        end
        FETCH_B: begin
          b_reg <= rom_data;
          state <= MULT;
        end
        MULT: begin
          p_reg <= ACC_W'(product);
          state <= WRITE;
        end
        WRITE: begin
          if (mode_q) begin
            ram[dst_q] <= acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) begin
              ovf <= 1'b1;
            end
          end else begin
            ram[dst_q] <= p_reg;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_engine.sv
// Directed bench for mult_acc_engine: store, accumulate/overflow, busy rejection,
// mid-operation reset and read-during-write, against hand-computed results.
module tb_mult_acc_engine;

  localparam int DW     = 4;
  localparam int ROM_AW = 3;
  localparam int RAM_AW = 3;
  localparam int ACC_W  = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ROM_AW-1:0] addr1;
  logic [ROM_AW-1:0] addr2;
  logic [RAM_AW-1:0] dst;
  logic              mode;
  logic [ROM_AW-1:0] rom_addr;
  logic [DW-1:0]     rom_data;
  logic [RAM_AW-1:0] rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              ovf;

  logic [DW-1:0] rom [8];

  int errors;
  int checks;
  int done_count;

  mult_acc_engine #(
    .DW(DW),
    .ROM_AW(ROM_AW),
    .RAM_AW(RAM_AW),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .addr1(addr1),
    .addr2(addr2),
    .dst(dst),
    .mode(mode),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [ROM_AW-1:0] a1, input logic [ROM_AW-1:0] a2,
                                input logic [RAM_AW-1:0] d, input logic m);
    addr1 = a1;
    addr2 = a2;
    dst   = d;
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs a full operation and leaves the bench in the IDLE cycle after DONE.
  task automatic run_op(input string tag, input logic [ROM_AW-1:0] a1, input logic [ROM_AW-1:0] a2,
                        input logic [RAM_AW-1:0] d, input logic m);
    apply_stimulus(a1, a2, d, m);
    for (int i = 0; i < 10 && done !== 1'b1; i++) begin
      step();
    end
    check({tag, "_done"}, done, 1);
    step();
  endtask

  task automatic read_check(input string tag, input logic [RAM_AW-1:0] addr, input logic [31:0] expected);
    rd_addr = addr;
    #1;
    check(tag, rd_data, expected);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rom[0] = 4'd3;  rom[1] = 4'd5;  rom[2] = 4'd7;  rom[3] = 4'd9;
    rom[4] = 4'd11; rom[5] = 4'd13; rom[6] = 4'd15; rom[7] = 4'd2;
    rst = 1'b1; start = 1'b0; addr1 = '0; addr2 = '0; dst = '0; mode = 1'b0; rd_addr = '0;

    step();
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rom_addr", rom_addr, 0);
    read_check("rst_ram4", 3'd4, 0);

    // Store 5*7 into entry 4 with cycle-by-cycle handshake checks.
    rd_addr = 3'd4;
    apply_stimulus(3'd1, 3'd2, 3'd4, 1'b0);
    addr1 = 3'd7; addr2 = 3'd7; dst = 3'd0; mode = 1'b1;
    check("st_t1_busy", busy, 1);
    check("st_t1_done", done, 0);
    check("st_t1_rom_addr", rom_addr, 1);
    step();
    check("st_t2_busy", busy, 1);
    check("st_t2_rom_addr", rom_addr, 2);
    step();
    check("st_t3_busy", busy, 1);
    check("st_t3_done", done, 0);
    step();
    check("st_t4_busy", busy, 1);
    check("st_t4_done", done, 0);
    check("st_t4_old", rd_data, 0);
    step();
    check("st_t5_busy", busy, 1);
    check("st_t5_done", done, 1);
    check("st_t5_new", rd_data, 35);
    step();
    check("st_t6_busy", busy, 0);
    check("st_t6_done", done, 0);
    check("st_ovf", ovf, 0);

    // 15*15 accumulated onto 35 wraps to 4 and sets overflow.
    run_op("acc", 3'd6, 3'd6, 3'd4, 1'b1);
    read_check("acc_ram4", 3'd4, 4);
    check("acc_ovf", ovf, 1);

    // A store overwrites the entry and leaves overflow sticky.
    run_op("st2", 3'd0, 3'd7, 3'd4, 1'b0);
    read_check("st2_ram4", 3'd4, 6);
    check("st2_ovf", ovf, 1);

    // Start held high with other operands throughout the busy window is ignored.
    done_count = 0;
    apply_stimulus(3'd3, 3'd4, 3'd1, 1'b0);
    start = 1'b1; addr1 = 3'd0; addr2 = 3'd0; dst = 3'd5; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) done_count++;
      step();
    end
    start = 1'b0;
    check("bz_done_count", done_count, 1);
    check("bz_t6_busy", busy, 0);
    step();
    check("bz_idle_busy", busy, 0);
    check("bz_idle_done", done, 0);
    read_check("bz_ram1", 3'd1, 99);
    read_check("bz_ram5", 3'd5, 0);
    run_op("bz_next", 3'd0, 3'd1, 3'd5, 1'b0);
    read_check("bz_next_ram5", 3'd5, 15);

    // Reset during FETCH_B abandons the op and clears everything.
    run_op("pre", 3'd1, 3'd2, 3'd2, 1'b0);
    read_check("pre_ram2", 3'd2, 35);
    apply_stimulus(3'd6, 3'd6, 3'd2, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_ovf", ovf, 0);
    done_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) done_count++;
      step();
    end
    check("mr_done_count", done_count, 0);
    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("mr_ram%0d", i), 3'(i), 0);
    end

    // Read-during-write on entry 3 with the largest operands in store mode.
    rd_addr = 3'd3;
    apply_stimulus(3'd6, 3'd6, 3'd3, 1'b0);
    step();
    step();
    step();
    check("rdw_write_old", rd_data, 0);
    check("rdw_write_done", done, 0);
    step();
    check("rdw_done_new", rd_data, 225);
    check("rdw_done_pulse", done, 1);
    check("rdw_ovf", ovf, 0);
    step();
    check("rdw_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
